// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div sequencer owning HI/LO for the MIPS EX stage.
// Optional macro MD_DIV0_HOLD_EN: divide by zero leaves HI/LO unchanged instead of LO=all-ones, HI=A.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        stall_md
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count;
    logic [31:0]   hold_hi, hold_lo;
    logic          hold_skip;
    logic          is_div, sgn, div0, skip;
    logic [63:0]   prod;
    logic [31:0]   abs_a, abs_b, quo_mag, rem_mag, quo, rem, res_hi, res_lo;

    assign busy     = state == BUSY;
    assign stall_md = md_use_D & (start | busy);

    // Result datapath: signed divide is done on magnitudes so 0x80000000/-1 wraps cleanly
    always_comb begin
        is_div  = md_op[1];
        sgn     = md_op == 2'd2;
        div0    = is_div & (B == '0);
        prod    = md_op[0] ? {32'b0, A} * {32'b0, B} : {{32{A[31]}}, A} * {{32{B[31]}}, B};
        abs_a   = (sgn && A[31]) ? -A : A;
        abs_b   = (sgn && B[31]) ? -B : B;
        quo_mag = (abs_b == '0) ? '0 : abs_a / abs_b;
        rem_mag = (abs_b == '0) ? '0 : abs_a % abs_b;
        quo     = (sgn && (A[31] ^ B[31])) ? -quo_mag : quo_mag;
        rem     = (sgn && A[31]) ? -rem_mag : rem_mag;
`ifdef MD_DIV0_HOLD_EN
        skip    = div0;
        res_hi  = is_div ? rem : prod[63:32];
        res_lo  = is_div ? quo : prod[31:0];
`else
        skip    = 1'b0;
        res_hi  = div0 ? A : is_div ? rem : prod[63:32];
        res_lo  = div0 ? 32'hFFFF_FFFF : is_div ? quo : prod[31:0];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: accept a start in IDLE, return when the countdown expires
    always_comb begin
        state_next = state;
        if (state == IDLE && start)           state_next = BUSY;
        if (state == BUSY && count == '0)     state_next = IDLE;
    end

    // Hold regs, countdown and HI/LO updates
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            HI        <= '0;
            LO        <= '0;
            hold_hi   <= '0;
            hold_lo   <= '0;
            hold_skip <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                hold_hi   <= res_hi;
                hold_lo   <= res_lo;
                hold_skip <= skip;
                count     <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            end else begin
                if (wr_hi) HI <= A;
                if (wr_lo) LO <= A;
            end
        end else if (count == '0) begin
            if (!hold_skip) begin
                HI <= hold_hi;
                LO <= hold_lo;
            end
        end else begin
            count <= count - 1'b1;
        end
    end
endmodule
